// File: rtl/tracker_pkg.sv
// -----------------------------------------------------------------------------
// tracker_pkg
// Shared definitions for the gray blob tracker:
//   - default image geometry (IMG_W_DEF x IMG_H_DEF)
//   - coordinate, count and sum widths
//   - frame and divider FSM state encodings
//   - the foreground decision used by the mask path
// -----------------------------------------------------------------------------
package tracker_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int CNT_W = 19;
    localparam int SUM_W = 28;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACCUM    = 1'b1
    } frame_state_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Foreground test: bright objects by default, dark objects when inverted.
    function automatic logic is_fg(input logic [7:0] gray,
                                   input logic [7:0] thr,
                                   input logic       inv);
        logic res;
        if (inv) begin
            res = (gray < thr);
        end else begin
            res = (gray >= thr);
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per cycle (NUM_W cycles).
// A start pulse while IDLE latches the operands; busy is high for the NUM_W
// iteration cycles, then done pulses for one cycle with the quotient valid.
// Start while not IDLE is ignored. Division by zero yields an all-ones quotient.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            one-cycle request
//   dividend/divisor operands (NUM_W / DEN_W bits)
//   busy, done       iteration in progress / result ready pulse
//   quotient         low Q_W bits of the quotient
// -----------------------------------------------------------------------------
module seq_divider
    import tracker_pkg::*;
#(
    parameter int NUM_W = 28,
    parameter int DEN_W = 19,
    parameter int Q_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int STEP_W = $clog2(NUM_W);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_W - 1);

    div_state_e        state_r;
    div_state_e        state_next_s;
    logic [STEP_W-1:0] step_r;
    logic [NUM_W-1:0]  quo_r;
    logic [DEN_W-1:0]  rem_r;
    logic [DEN_W-1:0]  den_r;
    logic              busy_r;
    logic              done_r;
    logic [DEN_W:0]    shifted_s;
    logic [DEN_W:0]    diff_s;
    logic              fits_s;

    // Shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        shifted_s = {rem_r, quo_r[NUM_W-1]};
        diff_s    = shifted_s - {1'b0, den_r};
        fits_s    = (shifted_s >= {1'b0, den_r});
    end

    // Divider FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = DIV;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DIV: begin
                if (step_r == STEP_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DIV;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Divider FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration datapath and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_r <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            den_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == DIV);
            done_r <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        quo_r  <= dividend;
                        rem_r  <= '0;
                        den_r  <= divisor;
                        step_r <= '0;
                    end
                end
                DIV: begin
                    // quo_r doubles as the dividend shift register
                    if (fits_s) begin
                        rem_r <= diff_s[DEN_W-1:0];
                        quo_r <= {quo_r[NUM_W-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted_s[DEN_W-1:0];
                        quo_r <= {quo_r[NUM_W-2:0], 1'b0};
                    end
                    step_r <= step_r + STEP_W'(1);
                end
                default: begin
                    step_r <= step_r;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quo_r[Q_W-1:0];

endmodule

// File: rtl/gray_blob_tracker.sv
// -----------------------------------------------------------------------------
// gray_blob_tracker
// Thresholds a gray pixel stream into a foreground mask and, per frame,
// accumulates foreground count, coordinate sums and bounding box. At frame end
// the totals are handed to two sequential dividers (x and y centroid) while the
// next frame accumulates; one report per completed frame is published.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   pix_valid/pix_sof/pix_gray pixel stream (no back-pressure)
//   threshold, invert          foreground rule, captured on the SOF pixel
//   mask_valid, mask_out       per-pixel foreground bit, 1-cycle latency
//   obj_valid                  one-cycle report strobe
//   obj_found, cx, cy          object flag and integer centroid
//   x_min/x_max/y_min/y_max    bounding box
//   pix_count                  foreground pixel count
//   busy                       centroid division in progress
// -----------------------------------------------------------------------------
module gray_blob_tracker
    import tracker_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int MIN_PIXELS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [7:0]       pix_gray,
    input  logic [7:0]       threshold,
    input  logic             invert,
    output logic             mask_valid,
    output logic             mask_out,
    output logic             obj_valid,
    output logic             obj_found,
    output logic [X_W-1:0]   cx,
    output logic [Y_W-1:0]   cy,
    output logic [X_W-1:0]   x_min,
    output logic [X_W-1:0]   x_max,
    output logic [Y_W-1:0]   y_min,
    output logic [Y_W-1:0]   y_max,
    output logic [CNT_W-1:0] pix_count,
    output logic             busy
);

    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    frame_state_e     frame_r, frame_next_s;
    logic [X_W-1:0]   x_r, pos_x_s;
    logic [Y_W-1:0]   y_r, pos_y_s;
    logic [7:0]       thr_r, thr_s;
    logic             inv_r, inv_s;
    logic             in_frame_s, fg_s, last_s;

    logic [CNT_W-1:0] cnt_r, base_cnt_s, cnt_s;
    logic [SUM_W-1:0] sx_r, base_sx_s, sx_s;
    logic [SUM_W-1:0] sy_r, base_sy_s, sy_s;
    logic [X_W-1:0]   xmin_r, base_xmin_s, xmin_s;
    logic [X_W-1:0]   xmax_r, base_xmax_s, xmax_s;
    logic [Y_W-1:0]   ymin_r, base_ymin_s, ymin_s;
    logic [Y_W-1:0]   ymax_r, base_ymax_s, ymax_s;

    logic             start_r;
    logic [SUM_W-1:0] div_sx_r, div_sy_r;
    logic [CNT_W-1:0] div_cnt_r;
    logic [X_W-1:0]   rep_xmin_r, rep_xmax_r;
    logic [Y_W-1:0]   rep_ymin_r, rep_ymax_r;

    logic             busy_x_s, busy_y_s, done_x_s, done_y_s, div_done_s, found_s;
    logic [X_W-1:0]   quo_x_s;
    logic [Y_W-1:0]   quo_y_s;

    logic             mask_valid_r, mask_out_r, obj_valid_r, obj_found_r;
    logic [X_W-1:0]   cx_r, x_min_r, x_max_r;
    logic [Y_W-1:0]   cy_r, y_min_r, y_max_r;
    logic [CNT_W-1:0] pix_count_r;

    // Pixel qualification, current position and accumulator fold.
    // A SOF pixel restarts everything from a clean base, so a partial frame is dropped.
    always_comb begin
        in_frame_s = pix_valid && (pix_sof || (frame_r == ACCUM));
        if (pix_sof) begin
            pos_x_s     = '0;
            pos_y_s     = '0;
            thr_s       = threshold;
            inv_s       = invert;
            base_cnt_s  = '0;
            base_sx_s   = '0;
            base_sy_s   = '0;
            base_xmin_s = X_LAST;
            base_xmax_s = '0;
            base_ymin_s = Y_LAST;
            base_ymax_s = '0;
        end else begin
            pos_x_s     = x_r;
            pos_y_s     = y_r;
            thr_s       = thr_r;
            inv_s       = inv_r;
            base_cnt_s  = cnt_r;
            base_sx_s   = sx_r;
            base_sy_s   = sy_r;
            base_xmin_s = xmin_r;
            base_xmax_s = xmax_r;
            base_ymin_s = ymin_r;
            base_ymax_s = ymax_r;
        end
        fg_s   = in_frame_s && is_fg(pix_gray, thr_s, inv_s);
        last_s = in_frame_s && (pos_x_s == X_LAST) && (pos_y_s == Y_LAST);
        if (fg_s) begin
            cnt_s  = base_cnt_s + CNT_W'(1);
            sx_s   = base_sx_s + SUM_W'(pos_x_s);
            sy_s   = base_sy_s + SUM_W'(pos_y_s);
            xmin_s = (pos_x_s < base_xmin_s) ? pos_x_s : base_xmin_s;
            xmax_s = (pos_x_s > base_xmax_s) ? pos_x_s : base_xmax_s;
            ymin_s = (pos_y_s < base_ymin_s) ? pos_y_s : base_ymin_s;
            ymax_s = (pos_y_s > base_ymax_s) ? pos_y_s : base_ymax_s;
        end else begin
            cnt_s  = base_cnt_s;
            sx_s   = base_sx_s;
            sy_s   = base_sy_s;
            xmin_s = base_xmin_s;
            xmax_s = base_xmax_s;
            ymin_s = base_ymin_s;
            ymax_s = base_ymax_s;
        end
    end

    // Frame FSM next-state logic
    always_comb begin
        frame_next_s = frame_r;
        case (frame_r)
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    frame_next_s = ACCUM;
                end else begin
                    frame_next_s = WAIT_SOF;
                end
            end
            ACCUM: begin
                if (last_s) begin
                    frame_next_s = WAIT_SOF;
                end else begin
                    frame_next_s = ACCUM;
                end
            end
            default: frame_next_s = WAIT_SOF;
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_r <= WAIT_SOF;
        end else begin
            frame_r <= frame_next_s;
        end
    end

    // Position counters, captured foreground rule and per-frame accumulators
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            thr_r  <= '0;
            inv_r  <= 1'b0;
            cnt_r  <= '0;
            sx_r   <= '0;
            sy_r   <= '0;
            xmin_r <= X_LAST;
            xmax_r <= '0;
            ymin_r <= Y_LAST;
            ymax_r <= '0;
        end else if (in_frame_s) begin
            thr_r <= thr_s;
            inv_r <= inv_s;
            if (last_s) begin
                x_r    <= '0;
                y_r    <= '0;
                cnt_r  <= '0;
                sx_r   <= '0;
                sy_r   <= '0;
                xmin_r <= X_LAST;
                xmax_r <= '0;
                ymin_r <= Y_LAST;
                ymax_r <= '0;
            end else begin
                if (pos_x_s == X_LAST) begin
                    x_r <= '0;
                    y_r <= pos_y_s + Y_W'(1);
                end else begin
                    x_r <= pos_x_s + X_W'(1);
                    y_r <= pos_y_s;
                end
                cnt_r  <= cnt_s;
                sx_r   <= sx_s;
                sy_r   <= sy_s;
                xmin_r <= xmin_s;
                xmax_r <= xmax_s;
                ymin_r <= ymin_s;
                ymax_r <= ymax_s;
            end
        end
    end

    // Frame-end hand-off: freeze totals (including the last pixel) for the dividers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_r    <= 1'b0;
            div_sx_r   <= '0;
            div_sy_r   <= '0;
            div_cnt_r  <= '0;
            rep_xmin_r <= '0;
            rep_xmax_r <= '0;
            rep_ymin_r <= '0;
            rep_ymax_r <= '0;
        end else begin
            start_r <= last_s;
            if (last_s) begin
                div_sx_r   <= sx_s;
                div_sy_r   <= sy_s;
                div_cnt_r  <= cnt_s;
                rep_xmin_r <= xmin_s;
                rep_xmax_r <= xmax_s;
                rep_ymin_r <= ymin_s;
                rep_ymax_r <= ymax_s;
            end
        end
    end

    seq_divider #(.NUM_W(SUM_W), .DEN_W(CNT_W), .Q_W(X_W)) u_div_x (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_r),
        .dividend (div_sx_r),
        .divisor  (div_cnt_r),
        .busy     (busy_x_s),
        .done     (done_x_s),
        .quotient (quo_x_s)
    );

    seq_divider #(.NUM_W(SUM_W), .DEN_W(CNT_W), .Q_W(Y_W)) u_div_y (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_r),
        .dividend (div_sy_r),
        .divisor  (div_cnt_r),
        .busy     (busy_y_s),
        .done     (done_y_s),
        .quotient (quo_y_s)
    );

    // Both dividers run in lockstep; either flag stands for the pair
    always_comb begin
        div_done_s = done_x_s && done_y_s;
        found_s    = (div_cnt_r >= MIN_CNT);
    end

    // Registered mask path and report outputs (report held until the next result)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_valid_r <= 1'b0;
            mask_out_r   <= 1'b0;
            obj_valid_r  <= 1'b0;
            obj_found_r  <= 1'b0;
            cx_r         <= '0;
            cy_r         <= '0;
            x_min_r      <= '0;
            x_max_r      <= '0;
            y_min_r      <= '0;
            y_max_r      <= '0;
            pix_count_r  <= '0;
        end else begin
            mask_valid_r <= in_frame_s;
            mask_out_r   <= fg_s;
            obj_valid_r  <= div_done_s;
            if (div_done_s) begin
                obj_found_r <= found_s;
                pix_count_r <= div_cnt_r;
                cx_r        <= found_s ? quo_x_s    : '0;
                cy_r        <= found_s ? quo_y_s    : '0;
                x_min_r     <= found_s ? rep_xmin_r : '0;
                x_max_r     <= found_s ? rep_xmax_r : '0;
                y_min_r     <= found_s ? rep_ymin_r : '0;
                y_max_r     <= found_s ? rep_ymax_r : '0;
            end
        end
    end

    assign mask_valid = mask_valid_r;
    assign mask_out   = mask_out_r;
    assign obj_valid  = obj_valid_r;
    assign obj_found  = obj_found_r;
    assign cx         = cx_r;
    assign cy         = cy_r;
    assign x_min      = x_min_r;
    assign x_max      = x_max_r;
    assign y_min      = y_min_r;
    assign y_max      = y_max_r;
    assign pix_count  = pix_count_r;
    assign busy       = busy_x_s || busy_y_s;

endmodule

// File: tb/tb_gray_blob_tracker.sv
// -----------------------------------------------------------------------------
// tb_gray_blob_tracker
// Two trackers (MIN_PIXELS=2 and MIN_PIXELS=1) on an 8x4 image share one
// stimulus stream. The stimulus side pushes expected mask bits and frame
// reports (computed from the whole frame image) into queues; a negedge monitor
// pops and compares whenever the DUTs present mask_valid or obj_valid.
// -----------------------------------------------------------------------------
module tb_gray_blob_tracker;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    typedef struct {
        int edge_n;
        int cnt;
        int cx;
        int cy;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
    } rep_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [7:0] pix_gray = 8'd0;
    logic [7:0] threshold = 8'd0;
    logic       invert = 1'b0;

    logic       a_mask_valid, a_mask_out, a_obj_valid, a_obj_found, a_busy;
    logic [9:0] a_cx, a_x_min, a_x_max;
    logic [8:0] a_cy, a_y_min, a_y_max;
    logic [18:0] a_pix_count;
    logic       b_mask_valid, b_mask_out, b_obj_valid, b_obj_found, b_busy;
    logic [9:0] b_cx, b_x_min, b_x_max;
    logic [8:0] b_cy, b_y_min, b_y_max;
    logic [18:0] b_pix_count;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic [7:0] img [NPIX];
    rep_t rep_q[$];
    bit   mask_q[$];

    gray_blob_tracker #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_gray(pix_gray), .threshold(threshold), .invert(invert),
        .mask_valid(a_mask_valid), .mask_out(a_mask_out), .obj_valid(a_obj_valid),
        .obj_found(a_obj_found), .cx(a_cx), .cy(a_cy), .x_min(a_x_min), .x_max(a_x_max),
        .y_min(a_y_min), .y_max(a_y_max), .pix_count(a_pix_count), .busy(a_busy)
    );

    gray_blob_tracker #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_gray(pix_gray), .threshold(threshold), .invert(invert),
        .mask_valid(b_mask_valid), .mask_out(b_mask_out), .obj_valid(b_obj_valid),
        .obj_found(b_obj_found), .cx(b_cx), .cy(b_cy), .x_min(b_x_min), .x_max(b_x_max),
        .y_min(b_y_min), .y_max(b_y_max), .pix_count(b_pix_count), .busy(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit fg(input logic [7:0] g, input int thr, input bit inv);
        return inv ? (int'(g) < thr) : (int'(g) >= thr);
    endfunction

    // Reference: list the foreground coordinates of the frame, then summarise them
    function automatic rep_t model(input int thr, input bit inv);
        rep_t r;
        int   xs[$];
        int   ys[$];
        int   sx = 0;
        int   sy = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (fg(img[y * W + x], thr, inv)) begin
                    xs.push_back(x);
                    ys.push_back(y);
                end
            end
        end
        r = '{0, 0, 0, 0, 0, 0, 0, 0};
        r.cnt = xs.size();
        if (r.cnt > 0) begin
            r.xmin = W; r.xmax = -1; r.ymin = H; r.ymax = -1;
            for (int i = 0; i < r.cnt; i++) begin
                sx += xs[i];
                sy += ys[i];
                if (xs[i] < r.xmin) r.xmin = xs[i];
                if (xs[i] > r.xmax) r.xmax = xs[i];
                if (ys[i] < r.ymin) r.ymin = ys[i];
                if (ys[i] > r.ymax) r.ymax = ys[i];
            end
            r.cx = sx / r.cnt;
            r.cy = sy / r.cnt;
        end
        return r;
    endfunction

    task automatic chk_rep(input string t, input rep_t e, input int minp, input int found,
                           input int cnt, input int cx, input int cy, input int xmin,
                           input int xmax, input int ymin, input int ymax);
        bit f;
        f = (e.cnt >= minp);
        check({t, "_found"}, found, int'(f));
        check({t, "_count"}, cnt, e.cnt);
        check({t, "_cx"}, cx, f ? e.cx : 0);
        check({t, "_cy"}, cy, f ? e.cy : 0);
        check({t, "_xmin"}, xmin, f ? e.xmin : 0);
        check({t, "_xmax"}, xmax, f ? e.xmax : 0);
        check({t, "_ymin"}, ymin, f ? e.ymin : 0);
        check({t, "_ymax"}, ymax, f ? e.ymax : 0);
    endtask

    // Monitor: compare mask and report outputs against queued expectations
    rep_t mon_e;
    bit   mon_m;
    always @(negedge clk) begin
        if (a_mask_valid || b_mask_valid) begin
            if (mask_q.size() == 0) begin
                total++; bad++;
                $display("FAIL mask_unexpected: mask_valid a=%0b b=%0b with no pixel in flight (cycle %0d)",
                         a_mask_valid, b_mask_valid, cyc);
            end else begin
                mon_m = mask_q.pop_front();
                check("mask_valid_a", int'(a_mask_valid), 1);
                check("mask_valid_b", int'(b_mask_valid), 1);
                check("mask_a", int'(a_mask_out), int'(mon_m));
                check("mask_b", int'(b_mask_out), int'(mon_m));
            end
        end
        if (a_obj_valid || b_obj_valid) begin
            if (rep_q.size() == 0) begin
                total++; bad++;
                $display("FAIL obj_unexpected: obj_valid a=%0b b=%0b with no report pending (cycle %0d)",
                         a_obj_valid, b_obj_valid, cyc);
            end else begin
                mon_e = rep_q.pop_front();
                check("obj_valid_a", int'(a_obj_valid), 1);
                check("obj_valid_b", int'(b_obj_valid), 1);
                check("latency", cyc, mon_e.edge_n + 30);
                check("busy_at_report", int'(a_busy), 0);
                chk_rep("rep_a", mon_e, 2, int'(a_obj_found), int'(a_pix_count), int'(a_cx),
                        int'(a_cy), int'(a_x_min), int'(a_x_max), int'(a_y_min), int'(a_y_max));
                chk_rep("rep_b", mon_e, 1, int'(b_obj_found), int'(b_pix_count), int'(b_cx),
                        int'(b_cy), int'(b_x_min), int'(b_x_max), int'(b_y_min), int'(b_y_max));
            end
        end
    end

    task automatic drive(input bit v, input bit s, input logic [7:0] g,
                         input logic [7:0] t, input bit inv);
        @(posedge clk);
        #1;
        pix_valid = v;
        pix_sof   = s;
        pix_gray  = g;
        threshold = t;
        invert    = inv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
    endtask

    // Send the first n pixels of img; threshold/invert are scrambled after SOF
    task automatic send_frame(input int n, input int thr, input bit inv, input bit gaps);
        rep_t r;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i > 0) && ($urandom_range(0, 3) == 0)) idle(1);
            if (i == 0) begin
                drive(1'b1, 1'b1, img[i], 8'(thr), inv);
            end else begin
                drive(1'b1, 1'b0, img[i], 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
            mask_q.push_back(fg(img[i], thr, inv));
            if (i == NPIX - 1) begin
                r = model(thr, inv);
                r.edge_n = cyc + 1;
                rep_q.push_back(r);
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (rep_q.size() != 0 || mask_q.size() != 0); i++) idle(1);
        check("drain_reports", rep_q.size(), 0);
        check("drain_masks", mask_q.size(), 0);
    endtask

    task automatic check_zero(input string t);
        check({t, "_a"}, int'(|{a_mask_valid, a_mask_out, a_obj_valid, a_obj_found, a_busy, a_cx,
                                a_cy, a_x_min, a_x_max, a_y_min, a_y_max, a_pix_count}), 0);
        check({t, "_b"}, int'(|{b_mask_valid, b_mask_out, b_obj_valid, b_obj_found, b_busy, b_cx,
                                b_cy, b_x_min, b_x_max, b_y_min, b_y_max, b_pix_count}), 0);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NPIX; i++) img[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        idle(3);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Non-SOF pixels before any SOF are ignored
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'd255, 8'd0, 1'b0);
        idle(2);

        // 2x2 blob
        fill(8'd0);
        img[1 * W + 2] = 8'd200; img[1 * W + 3] = 8'd200;
        img[2 * W + 2] = 8'd200; img[2 * W + 3] = 8'd200;
        send_frame(NPIX, 128, 1'b0, 1'b0);
        wait_drain();

        // Single foreground pixel
        fill(8'd0);
        img[2 * W + 5] = 8'd200;
        send_frame(NPIX, 128, 1'b0, 1'b0);
        wait_drain();

        // Inverted: only the last pixel is dark
        fill(8'd255);
        img[3 * W + 7] = 8'd127;
        send_frame(NPIX, 128, 1'b1, 1'b0);
        wait_drain();

        // Aborted partial frame followed by a full frame
        fill_random();
        send_frame(10, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        fill_random();
        send_frame(NPIX, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        wait_drain();

        // Back-to-back random frames, some with valid gaps
        for (int f = 0; f < 8; f++) begin
            fill_random();
            send_frame(NPIX, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), (f % 2) == 1);
        end
        wait_drain();

        // One-cycle reset during division: report dropped, outputs cleared
        fill_random();
        send_frame(NPIX, int'($urandom_range(0, 255)), 1'b0, 1'b0);
        idle(10);
        @(negedge clk);
        check("busy_mid_div", int'(a_busy), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        void'(rep_q.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset_mid_div");
        idle(40);

        // Normal frame after the reset
        fill(8'd0);
        img[0 * W + 6] = 8'd90; img[1 * W + 6] = 8'd90; img[1 * W + 7] = 8'd90;
        send_frame(NPIX, 64, 1'b0, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
